vga_timing: RTL and testbench

VGA_TIMING -- requirements
Module: vga_timing

---
 rtl/vga_timing.sv | 124 ++++++++++++
 tb/tb_vga_timing.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/vga_timing.sv
`default_nettype none
// ============================================================================
// Module      : vga_timing
// Description : VGA raster timing generator (hcount/vcount, sync, blanking).
//               Optional macro VGA_TIMING_CLKDIV_EN derives a half-rate pixel
//               tick from clk; without it clk is the pixel clock.
// Revision    : 1.0 - initial release
// ============================================================================
module vga_timing #(
    parameter int H_VISIBLE = 640,
    parameter int H_FP      = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BP      = 48,
    parameter int V_VISIBLE = 480,
    parameter int V_FP      = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BP      = 33
) (
    input  logic       clk,
    input  logic       reset,
    output logic [9:0] hcount,
    output logic [9:0] vcount,
    output logic       hsync,
    output logic       vsync,
    output logic       video_on,
    output logic       pix_tick,
    output logic       frame_start
);

    localparam int         c_H_TOTAL  = H_VISIBLE + H_FP + H_SYNC + H_BP;
    localparam int         c_V_TOTAL  = V_VISIBLE + V_FP + V_SYNC + V_BP;
    localparam logic [9:0] c_H_MAX    = 10'(c_H_TOTAL - 1);
    localparam logic [9:0] c_V_MAX    = 10'(c_V_TOTAL - 1);
    localparam logic [9:0] c_H_VIS    = 10'(H_VISIBLE);
    localparam logic [9:0] c_V_VIS    = 10'(V_VISIBLE);
    localparam logic [9:0] c_HS_START = 10'(H_VISIBLE + H_FP);
    localparam logic [9:0] c_HS_END   = 10'(H_VISIBLE + H_FP + H_SYNC - 1);
    localparam logic [9:0] c_VS_START = 10'(V_VISIBLE + V_FP);
    localparam logic [9:0] c_VS_END   = 10'(V_VISIBLE + V_FP + V_SYNC - 1);

    logic [9:0] r_hcount;
    logic [9:0] r_vcount;
    logic       r_hsync;
    logic       r_vsync;
    logic       r_video_on;
    logic       r_tick;
    logic       r_frame_start;

    logic [9:0] w_h_next;
    logic [9:0] w_v_next;
    logic       w_frame_wrap;

    // Next raster position; the registered decodes below are derived from it
    // so sync/blanking land in the same cycle as the counts they describe.
    always_comb begin
        w_h_next     = r_hcount;
        w_v_next     = r_vcount;
        w_frame_wrap = 1'b0;
        if (r_tick) begin
            if (r_hcount == c_H_MAX) begin
                w_h_next = '0;
                if (r_vcount == c_V_MAX) begin
                    w_v_next     = '0;
                    w_frame_wrap = 1'b1;
                end else begin
                    w_v_next = r_vcount + 10'd1;
                end
            end else begin
                w_h_next = r_hcount + 10'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_hcount      <= '0;
            r_vcount      <= '0;
            r_hsync       <= 1'b1;
            r_vsync       <= 1'b1;
            r_video_on    <= 1'b0;
            r_frame_start <= 1'b0;
        end else begin
            r_hcount      <= w_h_next;
            r_vcount      <= w_v_next;
            r_hsync       <= !((w_h_next >= c_HS_START) && (w_h_next <= c_HS_END));
            r_vsync       <= !((w_v_next >= c_VS_START) && (w_v_next <= c_VS_END));
            r_video_on    <= (w_h_next < c_H_VIS) && (w_v_next < c_V_VIS);
            r_frame_start <= w_frame_wrap;
        end
    end

`ifdef VGA_TIMING_CLKDIV_EN
    logic r_phase;

    // Phase lags the tick by one clk so the first tick appears on the 2nd clk.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_phase <= 1'b0;
            r_tick  <= 1'b0;
        end else begin
            r_phase <= ~r_phase;
            r_tick  <= r_phase;
        end
    end
`else
    always_ff @(posedge clk) begin
        if (reset) begin
            r_tick <= 1'b0;
        end else begin
            r_tick <= 1'b1;
        end
    end
`endif

    assign hcount      = r_hcount;
    assign vcount      = r_vcount;
    assign hsync       = r_hsync;
    assign vsync       = r_vsync;
    assign video_on    = r_video_on;
    assign pix_tick    = r_tick;
    assign frame_start = r_frame_start;

endmodule
`default_nettype wire

// File: tb/tb_vga_timing.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_vga_timing
// Description : Self-checking bench for vga_timing against a closed-form
//               raster model (tick count -> position -> sync/blank decode).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vga_timing;

    // Full horizontal timing; shortened vertical timing keeps a frame short.
    localparam int HV  = 640, HFP = 16, HS = 96, HBP = 48;
    localparam int VV  = 12,  VFP = 2,  VS = 2,  VBP = 3;
    localparam int HT  = HV + HFP + HS + HBP;
    localparam int VT  = VV + VFP + VS + VBP;
    localparam int FRAME = HT * VT;
`ifdef VGA_TIMING_CLKDIV_EN
    localparam int CPT = 2;
`else
    localparam int CPT = 1;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [9:0] hcount, vcount;
    logic       hsync, vsync, video_on, pix_tick, frame_start;

    vga_timing #(
        .H_VISIBLE(HV), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
        .V_VISIBLE(VV), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP)
    ) dut (
        .clk(clk), .reset(reset), .hcount(hcount), .vcount(vcount),
        .hsync(hsync), .vsync(vsync), .video_on(video_on),
        .pix_tick(pix_tick), .frame_start(frame_start)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    int k = 0;          // clk edges since reset release (0 = in reset)

    bit meas = 1'b0;
    int hs_low = 0, hs_fall_h = -1, hs_rise_h = -1, vo_fall_h = -1;
    int vs_low = 0, vs_fall_h = -1, vs_fall_v = -1, fs_k = -1, fs_cnt = 0;
    logic       prev_hsync = 1'b1, prev_vsync = 1'b1, prev_vo = 1'b0;
    logic [9:0] prev_h = '0, prev_v = '0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d (k=%0d)", tag, obs, exp, k);
        end
    endtask

    // Pixel ticks consumed by the counters before the sample taken after edge kk.
    function automatic int ticks_at(input int kk);
        if (kk < 1) return -1;
        return (CPT == 2) ? (kk - 1) / 2 : kk - 1;
    endfunction

    task automatic check_model();
        int n, h, v;
        logic e_hs, e_vs, e_vo, e_tick, e_fs;
        if (k == 0) begin
            h = 0; v = 0; e_hs = 1; e_vs = 1; e_vo = 0; e_tick = 0; e_fs = 0;
        end else begin
            n      = ticks_at(k);
            h      = n % HT;
            v      = (n / HT) % VT;
            e_hs   = !(h >= HV + HFP && h < HV + HFP + HS);
            e_vs   = !(v >= VV + VFP && v < VV + VFP + VS);
            e_vo   = (h < HV) && (v < VV);
            e_tick = (CPT == 2) ? (k % 2 == 0) : 1'b1;
            e_fs   = (n > 0) && (n % FRAME == 0) && (n != ticks_at(k - 1));
        end
        chk("hcount", 32'(hcount), 32'(h));
        chk("vcount", 32'(vcount), 32'(v));
        chk("hsync", 32'(hsync), 32'(e_hs));
        chk("vsync", 32'(vsync), 32'(e_vs));
        chk("video_on", 32'(video_on), 32'(e_vo));
        chk("pix_tick", 32'(pix_tick), 32'(e_tick));
        chk("frame_start", 32'(frame_start), 32'(e_fs));
    endtask

    task automatic monitor();
        if (meas) begin
            if (vcount == 10'd1 && !hsync) hs_low++;
            if (vcount == 10'd1 && prev_hsync && !hsync) hs_fall_h = int'(hcount);
            if (vcount == 10'd1 && !prev_hsync && hsync) hs_rise_h = int'(hcount);
            if (vcount == 10'd1 && prev_vo && !video_on) vo_fall_h = int'(hcount);
            if (fs_k < 0 && !vsync) vs_low++;
            if (fs_k < 0 && prev_vsync && !vsync) begin
                vs_fall_h = int'(hcount);
                vs_fall_v = int'(vcount);
            end
        end
        if (frame_start) begin
            fs_cnt++;
            if (fs_k < 0) fs_k = k;
            chk("fs_prev_h", 32'(prev_h), 32'(HT - 1));
            chk("fs_prev_v", 32'(prev_v), 32'(VT - 1));
        end
        prev_hsync = hsync; prev_vsync = vsync; prev_vo = video_on;
        prev_h = hcount; prev_v = vcount;
    endtask

    task automatic do_reset(input int cycles);
        reset = 1'b1;
        repeat (cycles) begin
            @(posedge clk); #1;
            k = 0;
            check_model();
            prev_hsync = hsync; prev_vsync = vsync; prev_vo = video_on;
            prev_h = hcount; prev_v = vcount;
        end
        reset = 1'b0;
    endtask

    task automatic run(input int clocks);
        repeat (clocks) begin
            @(posedge clk); #1;
            k++;
            check_model();
            monitor();
        end
    endtask

    initial begin
        do_reset(3);
        chk("rst_hsync", 32'(hsync), 32'd1);
        chk("rst_video_on", 32'(video_on), 32'd0);

        // Free run slightly over one frame from reset release.
        meas = 1'b1;
        run(CPT * (FRAME + 900));
        meas = 1'b0;
        chk("hsync_low_ticks", 32'(hs_low), 32'(HS * CPT));
        chk("hsync_fall_h", 32'(hs_fall_h), 32'(HV + HFP));
        chk("hsync_rise_h", 32'(hs_rise_h), 32'(HV + HFP + HS));
        chk("video_off_h", 32'(vo_fall_h), 32'(HV));
        chk("vsync_low_ticks", 32'(vs_low), 32'(VS * HT * CPT));
        chk("vsync_fall_h", 32'(vs_fall_h), 32'd0);
        chk("vsync_fall_v", 32'(vs_fall_v), 32'(VV + VFP));
        chk("frame_len_clks", 32'(fs_k), 32'(FRAME * CPT + 1));
        chk("frame_start_cnt", 32'(fs_cnt), 32'd1);

        // Mid-frame reset at (300,5).
        do_reset(1);
        run(CPT * (5 * HT + 300) + 1);
        chk("pre_rst_h", 32'(hcount), 32'd300);
        chk("pre_rst_v", 32'(vcount), 32'd5);
        do_reset(1);
        chk("mid_rst_h", 32'(hcount), 32'd0);
        chk("mid_rst_v", 32'(vcount), 32'd0);
        chk("mid_rst_hsync", 32'(hsync), 32'd1);
        chk("mid_rst_vsync", 32'(vsync), 32'd1);
        chk("mid_rst_video_on", 32'(video_on), 32'd0);
        run(CPT * (HT + 2));
        chk("after_line_v", 32'(vcount), 32'd1);

        // Random run lengths and reset widths.
        for (int i = 0; i < 4; i++) begin
            run(int'($urandom_range(50, 3000)));
            do_reset(int'($urandom_range(1, 3)));
        end
        run(int'($urandom_range(100, 1500)));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
